// File: rtl/avmm_ram_tester.sv
// Avalon-MM RAM self-test / fill engine.
// Writes a deterministic pattern over a word range, reads every word back,
// and records completion, a saturating mismatch count and the first failure.
//
// Handshake: a request (avm_write or avm_read) is accepted on a rising edge
// where it is high and avm_waitrequest is low. While waitrequest is high the
// address, data and request are held unchanged and are never withdrawn.
// Read data is taken on any edge in RWAIT where avm_readdatavalid is high.
// Only one read is ever outstanding.
module avmm_ram_tester #(
   parameter int ADDR_W   = 17,
   parameter int CNT_W    = 16,
   parameter int ERRCNT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [CNT_W:0]      word_count,
   input  logic                mode,
   input  logic [31:0]         seed,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [ERRCNT_W-1:0] err_count,
   output logic [ADDR_W-1:0]   err_addr,
   output logic [31:0]         err_data,
   output logic [31:0]         err_expected,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_read,
   output logic                avm_write,
   output logic [31:0]         avm_writedata,
   output logic [3:0]          avm_byteenable,
   input  logic [31:0]         avm_readdata,
   input  logic                avm_readdatavalid,
   input  logic                avm_waitrequest
);

   typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, FIN} state_t;

   state_t state, state_next;

   logic [ADDR_W-1:0]   base_r;
   logic [CNT_W:0]      count_r;
   logic                mode_r;
   logic [31:0]         seed_r;
   logic [CNT_W:0]      idx;
   logic                error_r;
   logic [ERRCNT_W-1:0] err_count_r;
   logic [ADDR_W-1:0]   err_addr_r;
   logic [31:0]         err_data_r;
   logic [31:0]         err_expected_r;

   logic [ADDR_W-1:0]   cur_addr;
   logic [31:0]         cur_pattern;
   logic [CNT_W:0]      idx_inc;
   logic                last;
   logic                wr_accept;
   logic                rd_accept;
   logic                rd_done;
   logic                mismatch;
   logic                req;

   // Address wraps at ADDR_W; pattern is regenerated identically for write and compare.
   assign cur_addr    = base_r + ADDR_W'({idx, 2'b00});
   assign cur_pattern = mode_r ? ~(32'(cur_addr)) : (seed_r + 32'(idx));
   assign idx_inc     = idx + (CNT_W+1)'(1);
   assign last        = (idx_inc == count_r);
   assign wr_accept   = (state == WR) && !avm_waitrequest;
   assign rd_accept   = (state == RD) && !avm_waitrequest;
   assign rd_done     = (state == RWAIT) && avm_readdatavalid;
   assign mismatch    = rd_done && (avm_readdata != cur_pattern);

   // Master outputs decode straight from registered state, so requests drop on the reset edge.
   assign avm_write      = (state == WR);
   assign avm_read       = (state == RD);
   assign req            = avm_write || avm_read;
   assign avm_address    = req ? cur_addr : '0;
   assign avm_writedata  = avm_write ? cur_pattern : '0;
   assign avm_byteenable = req ? 4'b1111 : 4'b0000;
   assign busy           = (state == WR) || (state == RD) || (state == RWAIT);
   assign done           = (state == FIN);
   assign error          = error_r;
   assign err_count      = err_count_r;
   assign err_addr       = err_addr_r;
   assign err_data       = err_data_r;
   assign err_expected   = err_expected_r;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode; abort only matters at an accepted write or returned read.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) state_next = (word_count == '0) ? FIN : WR;
         end
         WR: begin
            if (wr_accept) begin
               if (abort)     state_next = FIN;
               else if (last) state_next = RD;
            end
         end
         RD: begin
            if (rd_accept) state_next = RWAIT;
         end
         RWAIT: begin
            if (rd_done) state_next = (last || abort) ? FIN : RD;
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Test parameters, word index and error capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         base_r         <= '0;
         count_r        <= '0;
         mode_r         <= 1'b0;
         seed_r         <= '0;
         idx            <= '0;
         error_r        <= 1'b0;
         err_count_r    <= '0;
         err_addr_r     <= '0;
         err_data_r     <= '0;
         err_expected_r <= '0;
      end else begin
         if (state == IDLE && start) begin
            base_r         <= {base_addr[ADDR_W-1:2], 2'b00};
            count_r        <= word_count;
            mode_r         <= mode;
            seed_r         <= seed;
            idx            <= '0;
            error_r        <= 1'b0;
            err_count_r    <= '0;
            err_addr_r     <= '0;
            err_data_r     <= '0;
            err_expected_r <= '0;
         end
         if (wr_accept) begin
            // Read phase restarts the index at 0.
            idx <= (last || abort) ? '0 : idx_inc;
         end
         if (rd_done) begin
            idx <= idx_inc;
         end
         if (mismatch) begin
            error_r <= 1'b1;
            if (err_count_r != '1) err_count_r <= err_count_r + ERRCNT_W'(1);
            if (!error_r) begin
               err_addr_r     <= cur_addr;
               err_data_r     <= avm_readdata;
               err_expected_r <= cur_pattern;
            end
         end
      end
   end

endmodule

// File: tb/tb_avmm_ram_tester.sv
// Bench for avmm_ram_tester: a RAM slave model with programmable stalls and
// read corruption, advanced once per cycle on the falling edge, plus an
// expected-transaction scoreboard filled when each test is launched.
module tb_avmm_ram_tester;

   localparam int ADDR_W   = 17;
   localparam int CNT_W    = 16;
   localparam int ERRCNT_W = 16;
   localparam int STALL    = 3;

   logic                clk;
   logic                reset;
   logic                start;
   logic                abort;
   logic [ADDR_W-1:0]   base_addr;
   logic [CNT_W:0]      word_count;
   logic                mode;
   logic [31:0]         seed;
   logic                busy;
   logic                done;
   logic                error;
   logic [ERRCNT_W-1:0] err_count;
   logic [ADDR_W-1:0]   err_addr;
   logic [31:0]         err_data;
   logic [31:0]         err_expected;
   logic [ADDR_W-1:0]   avm_address;
   logic                avm_read;
   logic                avm_write;
   logic [31:0]         avm_writedata;
   logic [3:0]          avm_byteenable;
   logic [31:0]         avm_readdata;
   logic                avm_readdatavalid;
   logic                avm_waitrequest;

   int vectors     = 0;
   int miscompares = 0;

   // Scoreboard: {address, data} per write, address per read.
   logic [48:0] exp_wr_q[$];
   logic [16:0] exp_rd_q[$];

   // Slave model state.
   logic [31:0] mem [0:32767];
   int          cyc;
   int          wr_seen;
   int          rd_seen;
   int          stall_wr_num;
   int          stall_rd_num;
   int          wait_cnt;
   int          stall_total;
   int          first_wr_cyc;
   int          last_wr_cyc;
   bit          rd_pending;
   bit          stalled_prev;
   bit          any_req;
   logic [31:0] rd_data;
   logic [16:0] snap_addr;
   logic [31:0] snap_data;
   logic [1:0]  snap_req;
   bit          corr_en;
   logic [16:0] corr_a0;
   logic [16:0] corr_a1;
   logic [31:0] corr_d0;
   logic [31:0] corr_d1;

   avmm_ram_tester #(
      .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ERRCNT_W(ERRCNT_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .base_addr(base_addr), .word_count(word_count), .mode(mode), .seed(seed),
      .busy(busy), .done(done), .error(error), .err_count(err_count),
      .err_addr(err_addr), .err_data(err_data), .err_expected(err_expected),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .avm_waitrequest(avm_waitrequest)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] exp_addr(input logic [16:0] b, input int i);
      logic [16:0] base_al;
      base_al = {b[16:2], 2'b00};
      return base_al + 17'(i * 4);
   endfunction

   function automatic logic [31:0] exp_pat(input logic m, input logic [31:0] s,
                                           input logic [16:0] a, input int i);
      if (m) return ~{15'b0, a};
      return s + 32'(i);
   endfunction

   // One falling-edge step of the RAM slave: returns read data, decides
   // waitrequest for the current cycle and scores accepted requests.
   task automatic slave_tick();
      int target;
      logic [48:0] ew;
      logic [16:0] er;
      cyc++;
      if (stalled_prev) begin
         chk("hold_addr", avm_address, snap_addr);
         chk("hold_data", avm_writedata, snap_data);
         chk("hold_req", {avm_write, avm_read}, snap_req);
      end
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      if (rd_pending) begin
         avm_readdatavalid = 1'b1;
         avm_readdata      = rd_data;
         rd_pending        = 1'b0;
      end
      avm_waitrequest = 1'b0;
      stalled_prev    = 1'b0;
      if (avm_write || avm_read) begin
         any_req = 1'b1;
         target  = 0;
         if (avm_write && wr_seen == stall_wr_num) target = STALL;
         if (avm_read && rd_seen == stall_rd_num)  target = STALL;
         if (wait_cnt < target) begin
            avm_waitrequest = 1'b1;
            wait_cnt++;
            stall_total++;
            stalled_prev = 1'b1;
            snap_addr    = avm_address;
            snap_data    = avm_writedata;
            snap_req     = {avm_write, avm_read};
         end else begin
            wait_cnt = 0;
            chk("byteenable", avm_byteenable, 4'hF);
            if (avm_write) begin
               chk("wr_expected", exp_wr_q.size() != 0, 1);
               if (exp_wr_q.size() != 0) begin
                  ew = exp_wr_q.pop_front();
                  chk("wr_addr", avm_address, ew[48:32]);
                  chk("wr_data", avm_writedata, ew[31:0]);
               end
               mem[avm_address[16:2]] = avm_writedata;
               if (wr_seen == 0) first_wr_cyc = cyc;
               last_wr_cyc = cyc;
               wr_seen++;
            end else begin
               chk("rd_expected", exp_rd_q.size() != 0, 1);
               if (exp_rd_q.size() != 0) begin
                  er = exp_rd_q.pop_front();
                  chk("rd_addr", avm_address, er);
               end
               rd_data = mem[avm_address[16:2]];
               if (corr_en && avm_address == corr_a0)      rd_data = corr_d0;
               else if (corr_en && avm_address == corr_a1) rd_data = corr_d1;
               rd_pending = 1'b1;
               rd_seen++;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      slave_tick();
   endtask

   task automatic launch(input logic [16:0] b, input int cnt, input logic m,
                         input logic [31:0] s, input int n_wr, input int n_rd);
      logic [16:0] a;
      wr_seen = 0;
      rd_seen = 0;
      wait_cnt = 0;
      stall_total = 0;
      any_req = 1'b0;
      for (int i = 0; i < n_wr; i++) begin
         a = exp_addr(b, i);
         exp_wr_q.push_back({a, exp_pat(m, s, a, i)});
      end
      for (int i = 0; i < n_rd; i++) exp_rd_q.push_back(exp_addr(b, i));
      base_addr  = b;
      word_count = 17'(cnt);
      mode       = m;
      seed       = s;
      start      = 1'b1;
      tick();
      start = 1'b0;
      chk("start_write", avm_write, cnt != 0);
      chk("start_busy", busy, cnt != 0);
      chk("start_done", done, cnt == 0);
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 400 && !done; k++) tick();
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_in_done"}, busy, 0);
      tick();
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_wrq_empty"}, exp_wr_q.size(), 0);
      chk({tag, "_rdq_empty"}, exp_rd_q.size(), 0);
   endtask

   task automatic chk_errs(input string tag, input logic e, input logic [15:0] n,
                           input logic [16:0] a, input logic [31:0] d, input logic [31:0] x);
      chk({tag, "_error"}, error, e);
      chk({tag, "_err_count"}, err_count, n);
      chk({tag, "_err_addr"}, err_addr, a);
      chk({tag, "_err_data"}, err_data, d);
      chk({tag, "_err_expected"}, err_expected, x);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk_errs(tag, 1'b0, 16'h0, 17'h0, 32'h0, 32'h0);
      chk({tag, "_avm_address"}, avm_address, 0);
      chk({tag, "_avm_read"}, avm_read, 0);
      chk({tag, "_avm_write"}, avm_write, 0);
      chk({tag, "_avm_writedata"}, avm_writedata, 0);
      chk({tag, "_avm_byteenable"}, avm_byteenable, 0);
   endtask

   // Directed test sequence.
   initial begin
      bit found;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      base_addr = '0; word_count = '0; mode = 1'b0; seed = '0;
      avm_readdata = '0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
      cyc = 0; wr_seen = 0; rd_seen = 0; wait_cnt = 0; stall_total = 0;
      first_wr_cyc = 0; last_wr_cyc = 0;
      rd_pending = 1'b0; stalled_prev = 1'b0; any_req = 1'b0; rd_data = '0;
      snap_addr = '0; snap_data = '0; snap_req = '0;
      stall_wr_num = -1; stall_rd_num = -1;
      corr_en = 1'b0; corr_a0 = '0; corr_a1 = '0; corr_d0 = '0; corr_d1 = '0;

      repeat (3) tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();

      // Zero-wait slave, basic seed+index pattern.
      launch(17'h0, 4, 1'b0, 32'h100, 4, 4);
      wait_done("t1");
      chk("t1_write_span", last_wr_cyc - first_wr_cyc, 3);
      chk_errs("t1", 1'b0, 16'h0, 17'h0, 32'h0, 32'h0);

      // Stalls on the 2nd write and the 1st read.
      stall_wr_num = 1;
      stall_rd_num = 0;
      launch(17'h0, 4, 1'b0, 32'h100, 4, 4);
      wait_done("t2");
      chk("t2_stall_cycles", stall_total, 2 * STALL);
      chk_errs("t2", 1'b0, 16'h0, 17'h0, 32'h0, 32'h0);
      stall_wr_num = -1;
      stall_rd_num = -1;

      // Two corrupted words; only the first is captured.
      corr_en = 1'b1;
      corr_a0 = 17'h8; corr_d0 = 32'hDEADBEEF;
      corr_a1 = 17'hC; corr_d1 = 32'h12345678;
      launch(17'h0, 4, 1'b0, 32'h100, 4, 4);
      wait_done("t3");
      chk_errs("t3", 1'b1, 16'd2, 17'h8, 32'hDEADBEEF, 32'h102);
      corr_en = 1'b0;

      // Zero-length test: immediate done, no bus activity, errors cleared.
      launch(17'h40, 0, 1'b0, 32'h0, 0, 0);
      wait_done("t4");
      chk("t4_no_requests", any_req, 0);
      chk_errs("t4", 1'b0, 16'h0, 17'h0, 32'h0, 32'h0);

      // Inverted-address pattern with address wrap; low base bits dropped.
      launch(17'h1FFFA, 4, 1'b1, 32'h0, 4, 4);
      wait_done("t5");
      chk_errs("t5", 1'b0, 16'h0, 17'h0, 32'h0, 32'h0);

      // Abort while the 2nd write is stalled.
      stall_wr_num = 1;
      launch(17'h100, 8, 1'b0, 32'h55, 2, 0);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (avm_write && avm_waitrequest) found = 1'b1;
         else tick();
      end
      chk("t6_stall_seen", found, 1);
      abort = 1'b1;
      wait_done("t6");
      abort = 1'b0;
      chk("t6_writes", wr_seen, 2);
      chk("t6_reads", rd_seen, 0);
      stall_wr_num = -1;

      // Reset in the middle of the read phase.
      corr_en = 1'b1;
      corr_a0 = 17'h0; corr_d0 = 32'h00000BAD;
      corr_a1 = 17'h0; corr_d1 = 32'h00000BAD;
      launch(17'h0, 8, 1'b0, 32'h0, 8, 8);
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         if (avm_read && rd_seen >= 3) found = 1'b1;
         else tick();
      end
      chk("t7_read_phase", found, 1);
      chk("t7_error_before_reset", error, 1);
      reset = 1'b1;
      tick();
      chk_all_zero("t7_after_reset");
      reset = 1'b0;
      corr_en = 1'b0;
      rd_pending = 1'b0;
      stalled_prev = 1'b0;
      exp_wr_q.delete();
      exp_rd_q.delete();
      tick();
      chk("t7_idle_after_release", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/avmm_ram_tester.md
Name: avmm_ram_tester

Overview:
- Avalon-MM master that drives the initiator side of the on-chip RAM's Avalon-MM slave port.
- Writes a deterministic pattern over a word range, then reads every word back and compares it against the regenerated pattern.
- Reports completion, a saturating error count and the first failing address, data and expected value.
- Serves as the built-in RAM self-test / fill engine, ahead of the RAM's slave port in the system interconnect.

Parameters:
- ADDR_W, 17, byte-address width of the master port (32768 words x 4 bytes).
- CNT_W, 16, width of the word-count and index counters.
- ERRCNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a test when idle
- abort  in  1  level; stops the test at the next transaction boundary
- base_addr  in  ADDR_W  byte start address; bits [1:0] forced to 0
- word_count  in  CNT_W+1  number of 32-bit words to test
- mode  in  1  pattern select: 0 = seed+index, 1 = ~(word byte address)
- seed  in  32  pattern seed (mode 0)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion or abort
- error  out  1  sticky; at least one mismatch since the last start
- err_count  out  ERRCNT_W  mismatch count, saturating at all-ones
- err_addr  out  ADDR_W  byte address of the first mismatch
- err_data  out  32  read data at the first mismatch
- err_expected  out  32  expected data at the first mismatch
- avm_address  out  ADDR_W  master byte address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  32  write data
- avm_byteenable  out  4  always 4'b1111 while a request is asserted, else 0
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier
- avm_waitrequest  in  1  slave stall

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters cleared. Reset applies synchronously at any time, including mid-transfer, and the master drops read/write in the same edge.
- FSM states: IDLE, WR, RD, RWAIT, FIN.
- IDLE:
  - start=1 latches base_addr, word_count, mode and seed.
  - Clears error, err_count, err_addr, err_data and err_expected.
  - If word_count=0, goes to FIN. Otherwise goes to WR with index i=0.
  - start is ignored outside IDLE.
- Address and pattern rules:
  - Address for index i = base + 4*i, truncated to ADDR_W (wraps).
  - Pattern mode 0 = seed + i, zero-extended and mod 2^32.
  - Pattern mode 1 = bitwise NOT of the zero-extended address.
- WR:
  - avm_write=1 with address and pattern for i.
  - All request signals are held stable while avm_waitrequest=1.
  - A write is accepted on an edge where avm_write=1 and waitrequest=0; then i increments.
  - After the last accepted write: if abort=1, go to FIN; else go to RD with i=0.
  - Writes are issued back-to-back, one per cycle, when waitrequest=0.
- RD:
  - avm_read=1 with address for i, held until accepted (waitrequest=0), then go to RWAIT.
  - Exactly one outstanding read.
- RWAIT:
  - Waits for avm_readdatavalid; readdata is compared with the pattern for i.
  - On mismatch: err_count increments (saturating) and error is set. If this is the first mismatch, err_addr, err_data and err_expected are captured.
  - Then i increments. If i reaches word_count or abort=1, go to FIN; else go to RD.
  - No timeout: a missing readdatavalid hangs until reset.
- abort: sampled only at transaction acceptance (write accepted, or read data returned). A request is never withdrawn while waitrequest=1.
- FIN: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE. Error outputs hold until the next start or reset.
- busy is high in WR, RD and RWAIT.
- Latency: start seen at edge N puts avm_write high from cycle N+1.

Test Plan:
- Zero-wait slave with 1-cycle read latency; base=0, count=4, mode 0, seed=0x100:
  - Writes 0x100..0x103 to 0x0, 0x4, 0x8, 0xC on 4 consecutive cycles.
  - Then 4 reads, done pulse, error=0, err_count=0.
- Slave inserts 3 waitrequest cycles on the 2nd write and the 1st read: address, data and request are held stable throughout, and final results are unchanged.
- Slave corrupts the word at 0x8 to 0xDEADBEEF and the word at 0xC:
  - error=1, err_count=2.
  - err_addr=0x8, err_data=0xDEADBEEF, err_expected=0x102.
- Mode 1, base=0x1FFF8, count=4: addresses wrap to 0x1FFF8, 0x1FFFC, 0x0, 0x4, with data ~address, and no errors.
- count=0: done pulses the cycle after start, no avm_read/avm_write ever asserted.
- abort raised during the write phase with waitrequest high: the current write completes, then done pulses with no reads. A separate case asserts reset mid-read: all outputs are 0 on the next cycle.
